cnt_qos_timebase: RTL and testbench

- Parametrised successor to the accelerator's timebase/housekeeping counter.
- Derives refresh request/urgency from E-clock falling edges.
- Sequences power-on reset and PDS bus acquisition.
- Runs NCH independent I/O QoS hold-off timers that gate the 68K clock enable (MCKE).
- Sits beside the FSB controller and RAM controller in the CPLD.

---
 rtl/cnt_qos_timebase_if.sv | 16 +
 rtl/cnt_qos_timebase.sv | 192 +++++++++++++++++++
 tb/tb_cnt_qos_timebase.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cnt_qos_timebase_if.sv
// FSB-side bus-cycle and QoS signals shared between the FSB controller and the timebase.
interface cnt_qos_timebase_if #(
    parameter int NCH = 2
) ();
    // Bus-cycle signalling, no handshake: BACT is high for the whole FSB cycle and
    // BACTr is the same signal one CLK later. QoSCS is sampled with BACTr to retrigger a
    // channel. QoSEN and MCKE are level outputs that the timebase registers.
    logic           BACT;
    logic           BACTr;
    logic [NCH-1:0] QoSCS;
    logic [NCH-1:0] QoSEN;
    logic           MCKE;

    modport master (output BACT, BACTr, QoSCS, input QoSEN, MCKE);
    modport slave  (input BACT, BACTr, QoSCS, output QoSEN, MCKE);
endinterface

// File: rtl/cnt_qos_timebase.sv
// Timebase: E-clock refresh timer, power-on/PDS startup sequencer and I/O QoS hold-off timers.
// Optional macro CNT_SIM_FASTINIT_EN shortens each init phase to 4 refresh periods (simulation only).
module cnt_qos_timebase #(
    parameter int REF_PERIOD = 11,
    parameter int REF_URG    = 2,
    parameter int LT_W       = 12,
    parameter int NCH        = 2,
    parameter int QOS_W      = 3,
    parameter int QOS_HOLD   = 4
) (
    input  logic                   CLK,
    input  logic                   nRES,
    input  logic                   E,
    input  logic                   C8M,
    input  logic                   nRESin,
    input  logic                   nIPL2,
    cnt_qos_timebase_if.slave      bus,
    output logic                   RefReq,
    output logic                   RefUrg,
    output logic                   nRESout,
    output logic                   AoutOE,
    output logic                   nBR_IOB,
    output logic                   InitDone,
    output logic [1:0]             dbg_state_o,
    output logic [NCH*QOS_W-1:0]   dbg_qs_o
);
    localparam int T_W = $clog2(REF_PERIOD);
    localparam logic [T_W-1:0]   T_LAST = T_W'(REF_PERIOD - 1);
    localparam logic [T_W-1:0]   T_URG  = T_W'(REF_PERIOD - REF_URG);
    localparam logic [QOS_W-1:0] QS_TC  = QOS_W'(QOS_HOLD);
    localparam logic [QOS_W-1:0] QS_ONE = QOS_W'(1);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_NMI  = 2'd1,
        S_ARB  = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    logic [1:0]       e_sync_q;
    logic [1:0]       c8m_sync_q;
    logic             nresin_q;
    logic             nipl2_q;
    logic [NCH-1:0]   qoscs_q;
    logic [T_W-1:0]   t_q;
    logic [T_W-1:0]   t_d;
    logic             ref_req_q;
    logic             ref_urg_q;
    logic             ptick_q;
    logic [LT_W-1:0]  lt_q;
    state_t           state_q;
    logic             nresout_q;
    logic             aoutoe_q;
    logic             nbr_q;
    logic             initdone_q;
    logic [QOS_W-1:0] qs_q [NCH];
    logic [QOS_W-1:0] qs_d [NCH];
    logic [NCH-1:0]   qosen_q;
    logic             mcke_q;

    logic efall;
    logic c8mfall;
    logic istc;
    logic all_idle;

    always_comb begin
        efall   = e_sync_q[1] & ~e_sync_q[0];
        c8mfall = c8m_sync_q[1] & ~c8m_sync_q[0];
        t_d     = (t_q == T_LAST) ? '0 : t_q + T_W'(1);
`ifdef CNT_SIM_FASTINIT_EN
        istc    = ptick_q && (lt_q[1:0] == 2'b11);
`else
        istc    = ptick_q && (&lt_q);
`endif
    end

    // Input capture and the E-driven refresh timer; PTick marks the wrap back to state 0.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            e_sync_q   <= '0;
            c8m_sync_q <= '0;
            nresin_q   <= 1'b0;
            nipl2_q    <= 1'b0;
            qoscs_q    <= '0;
            t_q        <= '0;
            ref_req_q  <= 1'b0;
            ref_urg_q  <= 1'b0;
            ptick_q    <= 1'b0;
        end else begin
            e_sync_q   <= {e_sync_q[0], E};
            c8m_sync_q <= {c8m_sync_q[0], C8M};
            nresin_q   <= nRESin;
            nipl2_q    <= nIPL2;
            qoscs_q    <= bus.QoSCS;
            if (efall) begin
                t_q       <= t_d;
                ref_req_q <= (t_d != '0);
                ref_urg_q <= (t_d >= T_URG);
            end
            ptick_q    <= efall && (t_q == T_LAST);
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            lt_q <= '0;
        end else if (state_q == S_RUN) begin
            lt_q <= '0;
        end else if (ptick_q) begin
            lt_q <= lt_q + LT_W'(1);
        end
    end

    // Startup sequencer; nBR_IOB is a sticky record of the NMI button seen during NMI.
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state_q    <= S_HOLD;
            nresout_q  <= 1'b0;
            aoutoe_q   <= 1'b0;
            nbr_q      <= 1'b0;
            initdone_q <= 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (istc) state_q <= S_NMI;
                end
                S_NMI: begin
                    if (!nipl2_q) nbr_q <= 1'b1;
                    if (istc && nipl2_q) begin
                        state_q  <= S_ARB;
                        aoutoe_q <= ~nbr_q;
                    end
                end
                S_ARB: begin
                    aoutoe_q <= ~nbr_q;
                    if (istc) begin
                        state_q    <= S_RUN;
                        nresout_q  <= 1'b1;
                        initdone_q <= 1'b1;
                    end
                end
                S_RUN: begin
                end
                default: state_q <= S_HOLD;
            endcase
        end
    end

    // A retrigger beats a coincident PTick so an access at the terminal count restarts hold-off.
    always_comb begin
        all_idle = 1'b1;
        dbg_qs_o = '0;
        for (int i = 0; i < NCH; i++) begin
            qs_d[i] = qs_q[i];
            if (!nresin_q) begin
                qs_d[i] = QS_ONE;
            end else if (bus.BACTr && qoscs_q[i]) begin
                qs_d[i] = QS_ONE;
            end else if (qs_q[i] == '0) begin
                qs_d[i] = '0;
            end else if (ptick_q) begin
                qs_d[i] = (qs_q[i] == QS_TC) ? '0 : qs_q[i] + QS_ONE;
            end
            if (qs_q[i] != '0) all_idle = 1'b0;
            dbg_qs_o[i*QOS_W +: QOS_W] = qs_q[i];
        end
    end

    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            for (int i = 0; i < NCH; i++) qs_q[i] <= '0;
            qosen_q <= '0;
            mcke_q  <= 1'b1;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                qs_q[i] <= qs_d[i];
                if (!bus.BACT) qosen_q[i] <= (qs_q[i] != '0);
            end
            mcke_q <= bus.BACT || bus.BACTr || all_idle || c8mfall;
        end
    end

    assign RefReq      = ref_req_q;
    assign RefUrg      = ref_urg_q;
    assign nRESout     = nresout_q;
    assign AoutOE      = aoutoe_q;
    assign nBR_IOB     = nbr_q;
    assign InitDone    = initdone_q;
    assign bus.QoSEN   = qosen_q;
    assign bus.MCKE    = mcke_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_cnt_qos_timebase.sv
// Directed bench for cnt_qos_timebase; LT_W is overridden to 2 so each init phase is 4 PTicks.
module tb_cnt_qos_timebase;
    logic       CLK = 1'b0;
    logic       nRES;
    logic       E;
    logic       C8M;
    logic       nRESin;
    logic       nIPL2;
    logic       RefReq;
    logic       RefUrg;
    logic       nRESout;
    logic       AoutOE;
    logic       nBR_IOB;
    logic       InitDone;
    logic [1:0] dbg_state;
    logic [5:0] dbg_qs;

    int tests  = 0;
    int failed = 0;
    int t_exp  = 0;

    cnt_qos_timebase_if #(.NCH(2)) bus_if ();

    cnt_qos_timebase #(.LT_W(2)) dut (
        .CLK         (CLK),
        .nRES        (nRES),
        .E           (E),
        .C8M         (C8M),
        .nRESin      (nRESin),
        .nIPL2       (nIPL2),
        .bus         (bus_if),
        .RefReq      (RefReq),
        .RefUrg      (RefUrg),
        .nRESout     (nRESout),
        .AoutOE      (AoutOE),
        .nBR_IOB     (nBR_IOB),
        .InitDone    (InitDone),
        .dbg_state_o (dbg_state),
        .dbg_qs_o    (dbg_qs)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_RefReq",   RefReq,   0);
        chk("rst_RefUrg",   RefUrg,   0);
        chk("rst_nRESout",  nRESout,  0);
        chk("rst_AoutOE",   AoutOE,   0);
        chk("rst_nBR_IOB",  nBR_IOB,  0);
        chk("rst_QoSEN",    bus_if.QoSEN, 0);
        chk("rst_MCKE",     bus_if.MCKE,  1);
        chk("rst_InitDone", InitDone, 0);
        chk("rst_state",    dbg_state, 0);
    endtask

    // One E period; with retrig set, a QoS channel-0 access lands on the PTick cycle.
    task automatic e_cycle(input bit retrig);
        @(negedge CLK);
        E = 1'b0;
        if (retrig) begin
            bus_if.BACT  = 1'b1;
            bus_if.QoSCS = 2'b01;
        end
        @(negedge CLK);
        @(negedge CLK);
        if (retrig) begin
            bus_if.BACTr = 1'b1;
            bus_if.BACT  = 1'b0;
        end
        t_exp = (t_exp == 10) ? 0 : t_exp + 1;
        chk("RefReq", RefReq, (t_exp != 0));
        chk("RefUrg", RefUrg, (t_exp >= 9));
        E = 1'b1;
        @(negedge CLK);
        if (retrig) begin
            bus_if.BACTr = 1'b0;
            bus_if.QoSCS = 2'b00;
        end
        @(negedge CLK);
    endtask

    task automatic run_pticks(input int n);
        int k = 0;
        while (k < n) begin
            e_cycle(1'b0);
            if (t_exp == 0) k++;
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRES  = 1'b0;
        t_exp = 0;
        repeat (2) @(negedge CLK);
        nRES = 1'b1;
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        failed++;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        nRES = 1'b0; E = 1'b1; C8M = 1'b0; nRESin = 1'b1; nIPL2 = 1'b1;
        bus_if.BACT = 1'b0; bus_if.BACTr = 1'b0; bus_if.QoSCS = 2'b00;
        repeat (3) @(negedge CLK);
        chk_reset_outputs();
        nRES = 1'b1;
        repeat (3) @(negedge CLK);

        // Timers reload to 1 out of reset and clear after 4 PTicks; HOLD lasts 4 PTicks.
        run_pticks(3);
        chk("hold_state", dbg_state, 0);
        chk("boot_qs4", dbg_qs, 6'h24);
        chk("boot_qosen", bus_if.QoSEN, 2'b11);
        chk("boot_mcke0", bus_if.MCKE, 0);
        run_pticks(1);
        chk("nmi_state", dbg_state, 1);
        chk("boot_qs0", dbg_qs, 6'h00);
        chk("boot_qosen0", bus_if.QoSEN, 2'b00);
        chk("boot_mcke1", bus_if.MCKE, 1);

        // Asynchronous reset in the middle of NMI.
        run_pticks(1);
        @(negedge CLK);
        nRES = 1'b0;
        t_exp = 0;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge CLK);
        nRES = 1'b1;
        repeat (3) @(negedge CLK);

        // Clean startup with the button released throughout.
        run_pticks(4);
        chk("s2_nmi", dbg_state, 1);
        chk("s2_nmi_aoe", AoutOE, 0);
        run_pticks(4);
        chk("s2_arb", dbg_state, 2);
        chk("s2_arb_aoe", AoutOE, 1);
        chk("s2_arb_nres", nRESout, 0);
        chk("s2_arb_done", InitDone, 0);
        run_pticks(4);
        chk("s2_run", dbg_state, 3);
        chk("s2_run_nres", nRESout, 1);
        chk("s2_run_done", InitDone, 1);
        chk("s2_run_nbr", nBR_IOB, 0);
        chk("s2_run_aoe", AoutOE, 1);

        // Bus cycle to channel 0.
        @(negedge CLK);
        bus_if.BACT = 1'b1; bus_if.QoSCS = 2'b01;
        @(negedge CLK);
        bus_if.BACTr = 1'b1;
        chk("bus_mcke", bus_if.MCKE, 1);
        @(negedge CLK);
        bus_if.BACT = 1'b0;
        @(negedge CLK);
        bus_if.BACTr = 1'b0; bus_if.QoSCS = 2'b00;
        chk("bus_qosen", bus_if.QoSEN, 2'b01);
        chk("bus_qs1", dbg_qs, 6'h01);
        @(negedge CLK);
        chk("hold_mcke0", bus_if.MCKE, 0);

        // C8M falling edge lets one MCKE pulse through while held off.
        C8M = 1'b1;
        repeat (2) @(negedge CLK);
        C8M = 1'b0;
        repeat (2) @(negedge CLK);
        chk("c8m_mcke1", bus_if.MCKE, 1);
        @(negedge CLK);
        chk("c8m_mcke0", bus_if.MCKE, 0);

        run_pticks(3);
        chk("qs_at_tc", dbg_qs, 6'h04);
        chk("qosen_ch1_low", bus_if.QoSEN, 2'b01);
        chk("tc_mcke0", bus_if.MCKE, 0);

        // Retrigger coincident with the PTick at the terminal count.
        while (t_exp != 10) e_cycle(1'b0);
        e_cycle(1'b1);
        chk("retrig_qs1", dbg_qs, 6'h01);
        chk("retrig_qosen", bus_if.QoSEN, 2'b01);
        run_pticks(3);
        chk("retrig_qs4", dbg_qs, 6'h04);
        run_pticks(1);
        chk("expire_qs0", dbg_qs, 6'h00);
        chk("expire_qosen", bus_if.QoSEN, 2'b00);
        chk("expire_mcke", bus_if.MCKE, 1);

        // Board reset in RUN reloads the timers only.
        @(negedge CLK);
        nRESin = 1'b0;
        repeat (2) @(negedge CLK);
        chk("nresin_qs", dbg_qs, 6'h09);
        chk("nresin_state", dbg_state, 3);
        chk("nresin_nres", nRESout, 1);
        nRESin = 1'b1;

        // Startup with the NMI button pressed during NMI.
        do_reset();
        run_pticks(4);
        chk("s3_nmi", dbg_state, 1);
        chk("s3_nbr0", nBR_IOB, 0);
        @(negedge CLK);
        nIPL2 = 1'b0;
        repeat (2) @(negedge CLK);
        nIPL2 = 1'b1;
        repeat (2) @(negedge CLK);
        chk("s3_nbr_set", nBR_IOB, 1);
        run_pticks(3);
        nIPL2 = 1'b0;
        run_pticks(1);
        chk("s3_wait_nmi", dbg_state, 1);
        chk("s3_wait_nbr", nBR_IOB, 1);
        nIPL2 = 1'b1;
        run_pticks(4);
        chk("s3_arb", dbg_state, 2);
        chk("s3_arb_aoe", AoutOE, 0);
        chk("s3_arb_nbr", nBR_IOB, 1);
        chk("s3_arb_nres", nRESout, 0);
        run_pticks(4);
        chk("s3_run", dbg_state, 3);
        chk("s3_run_nres", nRESout, 1);
        chk("s3_run_done", InitDone, 1);
        chk("s3_run_aoe", AoutOE, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
